hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/rapid_pkg.sv | 11 +
 rtl/fwd_mux.sv | 25 ++
 rtl/hazard_forward_unit.sv | 133 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - shared width, register and FSM state definitions for the hazard/forward unit
package rapid_pkg;
   localparam int XLEN = 32;
   localparam logic [4:0] REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_STALL = 2'd1,
      MC_BUSY    = 2'd2
   } hfu_state_t;
endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - priority forwarding select for one EX operand
module fwd_mux
   import rapid_pkg::*;
#(
   parameter int NUM_FWD = 2
) (
   input  logic [4:0]                     i_rs,
   input  logic [XLEN-1:0]                i_rs_data,
   input  logic [NUM_FWD-1:0]             i_fwd_wen,
   input  logic [NUM_FWD-1:0][4:0]        i_fwd_rd,
   input  logic [NUM_FWD-1:0][XLEN-1:0]   i_fwd_data,
   output logic [XLEN-1:0]                o_data
);

   // Walk oldest to youngest so the youngest matching stage is written last and wins.
   always_comb begin
      o_data = i_rs_data;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if ((i_rs != REG_X0) && i_fwd_wen[k] && (i_fwd_rd[k] == i_rs)) begin
            o_data = i_fwd_data[k];
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding plus load-use / multicycle stall control
// Optional stall-cycle counter port o_stall_cycles enabled by HFU_PERF_CNT_EN.
module hazard_forward_unit
   import rapid_pkg::*;
#(
   parameter int NUM_FWD  = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_id_valid,
   input  logic [4:0]                     i_id_rs1,
   input  logic [4:0]                     i_id_rs2,
   input  logic                           i_ex_valid,
   input  logic                           i_ex_is_load,
   input  logic [4:0]                     i_ex_rd,
   input  logic                           i_ex_mc_start,
   input  logic                           i_mc_done,
   input  logic [4:0]                     i_ex_rs1,
   input  logic [4:0]                     i_ex_rs2,
   input  logic [XLEN-1:0]                i_ex_rs1_data,
   input  logic [XLEN-1:0]                i_ex_rs2_data,
   input  logic [NUM_FWD-1:0]             i_fwd_wen,
   input  logic [NUM_FWD-1:0][4:0]        i_fwd_rd,
   input  logic [NUM_FWD-1:0][XLEN-1:0]   i_fwd_data,
   output logic [XLEN-1:0]                o_forward_rs1,
   output logic [XLEN-1:0]                o_forward_rs2,
   output logic                           o_stall_id,
   output logic                           o_bubble_ex,
   output logic                           o_busy
`ifdef HFU_PERF_CNT_EN
   ,
   output logic [31:0]                    o_stall_cycles
`endif
);

   // The IDLE cycle that detects the hazard is the first stall cycle, so the counter covers the rest.
   localparam logic [2:0] LOAD_CNT_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

   hfu_state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       lh;

   fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rs1 (
      .i_rs       (i_ex_rs1),
      .i_rs_data  (i_ex_rs1_data),
      .i_fwd_wen  (i_fwd_wen),
      .i_fwd_rd   (i_fwd_rd),
      .i_fwd_data (i_fwd_data),
      .o_data     (o_forward_rs1)
   );

   fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rs2 (
      .i_rs       (i_ex_rs2),
      .i_rs_data  (i_ex_rs2_data),
      .i_fwd_wen  (i_fwd_wen),
      .i_fwd_rd   (i_fwd_rd),
      .i_fwd_data (i_fwd_data),
      .o_data     (o_forward_rs2)
   );

   assign lh = i_id_valid & i_ex_valid & i_ex_is_load & (i_ex_rd != REG_X0)
             & ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      o_stall_id  = 1'b0;
      o_bubble_ex = 1'b0;
      case (state_q)
         IDLE: begin
            // A multicycle launch keeps its EX instruction, so it must not be bubbled by a coincident load hazard.
            if (i_ex_valid && i_ex_mc_start) begin
               o_stall_id = 1'b1;
               state_d    = MC_BUSY;
            end else if (lh) begin
               o_stall_id  = 1'b1;
               o_bubble_ex = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_d = LOAD_STALL;
                  cnt_d   = LOAD_CNT_INIT;
               end
            end
         end
         LOAD_STALL: begin
            o_stall_id  = 1'b1;
            o_bubble_ex = 1'b1;
            if (cnt_q == 3'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         MC_BUSY: begin
            o_stall_id = 1'b1;
            if (i_mc_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   assign o_busy = (state_q != IDLE);

`ifdef HFU_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stall_cnt_q <= 32'd0;
      end else if (o_stall_id && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign o_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - scoreboard bench for hazard_forward_unit (LOAD_LAT=3 and LOAD_LAT=4 instances)
module tb_hazard_forward_unit;
   import rapid_pkg::*;

   typedef struct {
      string       name;
      logic [2:0]  ctl;
      logic [31:0] f1;
      logic [31:0] f2;
      bit          chk4;
      logic [1:0]  ctl4;
   } exp_t;

   logic clk;
   logic rst;
   logic id_valid;
   logic [4:0] id_rs1, id_rs2;
   logic ex_valid, ex_is_load, ex_mc_start, mc_done;
   logic [4:0] ex_rd, ex_rs1, ex_rs2;
   logic [31:0] ex_rs1_data, ex_rs2_data;
   logic [1:0] fwd_wen;
   logic [1:0][4:0] fwd_rd;
   logic [1:0][31:0] fwd_data;
   logic [31:0] fwd1, fwd2, fwd1_4, fwd2_4;
   logic stall, bubble, busy, stall4, bubble4, busy4;
`ifdef HFU_PERF_CNT_EN
   logic [31:0] stall_cycles, stall_cycles4;
`endif

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   hazard_forward_unit #(.NUM_FWD(2), .LOAD_LAT(3)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
      .i_ex_mc_start(ex_mc_start), .i_mc_done(mc_done),
      .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
      .i_ex_rs1_data(ex_rs1_data), .i_ex_rs2_data(ex_rs2_data),
      .i_fwd_wen(fwd_wen), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
      .o_forward_rs1(fwd1), .o_forward_rs2(fwd2),
      .o_stall_id(stall), .o_bubble_ex(bubble), .o_busy(busy)
`ifdef HFU_PERF_CNT_EN
      , .o_stall_cycles(stall_cycles)
`endif
   );

   hazard_forward_unit #(.NUM_FWD(2), .LOAD_LAT(4)) dut4 (
      .i_clk(clk), .i_rst(rst),
      .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
      .i_ex_mc_start(ex_mc_start), .i_mc_done(mc_done),
      .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
      .i_ex_rs1_data(ex_rs1_data), .i_ex_rs2_data(ex_rs2_data),
      .i_fwd_wen(fwd_wen), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
      .o_forward_rs1(fwd1_4), .o_forward_rs2(fwd2_4),
      .o_stall_id(stall4), .o_bubble_ex(bubble4), .o_busy(busy4)
`ifdef HFU_PERF_CNT_EN
      , .o_stall_cycles(stall_cycles4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: outputs are sampled mid-cycle, after the driver has settled the inputs.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         if ({stall, bubble, busy} !== e.ctl || fwd1 !== e.f1 || fwd2 !== e.f2) begin
            n_fail++;
            $display("FAIL %s: got stall/bubble/busy=%b fwd1=%h fwd2=%h, expected %b %h %h",
                     e.name, {stall, bubble, busy}, fwd1, fwd2, e.ctl, e.f1, e.f2);
         end
         if (e.chk4) begin
            n_tests++;
            if ({stall4, busy4} !== e.ctl4) begin
               n_fail++;
               $display("FAIL %s_lat4: got stall/busy=%b, expected %b", e.name, {stall4, busy4}, e.ctl4);
            end
         end
      end
   end

   task automatic step(input string name, input logic [2:0] ctl, input logic [31:0] f1,
                       input logic [31:0] f2, input bit chk4, input logic [1:0] ctl4);
      exp_t e;
      e.name = name; e.ctl = ctl; e.f1 = f1; e.f2 = f2; e.chk4 = chk4; e.ctl4 = ctl4;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_hazard();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0;
      ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_mc_start = 0; mc_done = 0;
   endtask

   initial begin
      clear_hazard();
      ex_rs1 = 0; ex_rs2 = 0; ex_rs1_data = 0; ex_rs2_data = 0;
      fwd_wen = '0; fwd_rd = '0; fwd_data = '0;
      rst = 1;
      @(posedge clk); #1;
      step("reset", 3'b000, 32'h0, 32'h0, 1, 2'b00);
      rst = 0;

      ex_rs1 = 5; ex_rs1_data = 32'h1111; ex_rs2 = 6; ex_rs2_data = 32'h2222;
      fwd_wen = 2'b11; fwd_rd[0] = 5; fwd_data[0] = 32'hAAAA; fwd_rd[1] = 5; fwd_data[1] = 32'hBBBB;
      step("fwd_prio_s0", 3'b000, 32'hAAAA, 32'h2222, 0, 2'b00);
      fwd_wen = 2'b10;
      step("fwd_prio_s1", 3'b000, 32'hBBBB, 32'h2222, 0, 2'b00);
      fwd_rd[1] = 9;
      step("fwd_nomatch", 3'b000, 32'h1111, 32'h2222, 0, 2'b00);
      ex_rs1 = 0; ex_rs1_data = 32'h55; ex_rs2 = 0; ex_rs2_data = 0;
      fwd_wen = 2'b11; fwd_rd[0] = 0; fwd_data[0] = 32'h1234; fwd_rd[1] = 0;
      step("fwd_x0", 3'b000, 32'h55, 32'h0, 0, 2'b00);
      ex_rs2 = 3; ex_rs2_data = 32'h7777; fwd_wen = 2'b10; fwd_rd[0] = 3; fwd_rd[1] = 3; fwd_data[1] = 32'hCCCC;
      step("fwd_rs2_s1", 3'b000, 32'h55, 32'hCCCC, 0, 2'b00);

      ex_rs1 = 0; ex_rs2 = 0; ex_rs1_data = 0; ex_rs2_data = 0;
      fwd_wen = '0; fwd_rd = '0; fwd_data = '0;

      id_valid = 1; id_rs1 = 0; ex_valid = 1; ex_is_load = 1; ex_rd = 0;
      step("lh_rd_x0", 3'b000, 0, 0, 1, 2'b00);
      id_rs1 = 1; id_rs2 = 7; ex_rd = 7;
      step("lu_c0", 3'b110, 0, 0, 1, 2'b10);
      step("lu_c1", 3'b111, 0, 0, 1, 2'b11);
      step("lu_c2", 3'b111, 0, 0, 1, 2'b11);
      clear_hazard();
      step("lu_c3", 3'b000, 0, 0, 1, 2'b11);
      step("lu_c4", 3'b000, 0, 0, 1, 2'b00);

      mc_done = 1;
      step("done_in_idle", 3'b000, 0, 0, 1, 2'b00);
      mc_done = 0;

      id_valid = 1; id_rs2 = 7; ex_valid = 1; ex_is_load = 1; ex_rd = 7; ex_mc_start = 1;
      step("mc_c0_prio", 3'b100, 0, 0, 1, 2'b10);
      for (int i = 1; i <= 9; i++) step("mc_busy", 3'b101, 0, 0, 1, 2'b11);
      mc_done = 1;
      step("mc_done", 3'b101, 0, 0, 1, 2'b11);
      clear_hazard();
      step("mc_after", 3'b000, 0, 0, 1, 2'b00);

      id_valid = 1; id_rs2 = 7; ex_valid = 1; ex_is_load = 1; ex_rd = 7;
      step("rst_c0", 3'b110, 0, 0, 1, 2'b10);
      clear_hazard();
      rst = 1;
      step("rst_c1", 3'b111, 0, 0, 1, 2'b11);
      rst = 0;
`ifdef HFU_PERF_CNT_EN
      n_tests++;
      if (stall_cycles4 !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_reset: got %h, expected 00000000", stall_cycles4);
      end
`endif
      step("rst_c2", 3'b000, 0, 0, 1, 2'b00);

`ifdef HFU_PERF_CNT_EN
      dut.stall_cnt_q = 32'hFFFF_FFFE;
      id_valid = 1; id_rs2 = 7; ex_valid = 1; ex_is_load = 1; ex_rd = 7;
      step("sat_c0", 3'b110, 0, 0, 0, 2'b00);
      clear_hazard();
      step("sat_c1", 3'b111, 0, 0, 0, 2'b00);
      step("sat_c2", 3'b111, 0, 0, 0, 2'b00);
      n_tests++;
      if (stall_cycles !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL perf_saturate: got %h, expected FFFFFFFF", stall_cycles);
      end
`endif

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
